// File: rtl/sram_arbiter_if.sv
// Single-port SRAM request bundle shared by requesters and controller.
// master drives the request side, slave answers with data and ready.
interface sram_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              read_en;
  logic              write_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              ready;

  modport master (
    output read_en,
    output write_en,
    output address,
    output write_data,
    input  read_data,
    input  ready
  );

  modport slave (
    input  read_en,
    input  write_en,
    input  address,
    input  write_data,
    output read_data,
    output ready
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of the single SRAM controller port.
// Tie policy: fixed p0 priority, or round robin with SRAM_ARB_ROUND_ROBIN_EN.
module sram_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  p0,
  sram_arbiter_if.slave  p1,
  sram_arbiter_if.master mem,
  output logic [1:0]     grant,
  output logic           busy
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t            r_state;
  logic              r_owner;
  logic [DATA_W-1:0] r_rd_buf0;
  logic [DATA_W-1:0] r_rd_buf1;

  logic              w_pend0;
  logic              w_pend1;
  logic              w_any;
  logic              w_win;
  logic              w_sel;
  logic              w_done;
  logic              w_done0;
  logic              w_done1;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_pend0 = p0.read_en | p0.write_en;
  assign w_pend1 = p1.read_en | p1.write_en;
  assign w_any   = w_pend0 | w_pend1;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic r_last;

  // On a tie p1 wins only if p0 was served last.
  assign w_win = w_pend1 & (~w_pend0 | ~r_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_done) begin
      r_last <= r_owner;
    end
  end
`else
  assign w_win = w_pend1 & ~w_pend0;
`endif

  // w_sel: 0 = p0, 1 = p1 drives the controller this cycle
  assign w_sel = (r_state == S_BUSY) ? r_owner : w_win;

  assign busy    = (r_state == S_BUSY);
  assign w_done  = busy & mem.ready;
  assign w_done0 = w_done & ~r_owner;
  assign w_done1 = w_done &  r_owner;

  always_comb begin
    grant = 2'b00;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          grant = w_win ? 2'b10 : 2'b01;
        end
      end
      S_BUSY: begin
        grant = r_owner ? 2'b10 : 2'b01;
      end
      default: grant = 2'b00;
    endcase
  end

  assign w_addr  = w_sel ? p1.address    : p0.address;
  assign w_wdata = w_sel ? p1.write_data : p0.write_data;

  // A read takes precedence when a port raises both enables.
  always_comb begin
    mem.read_en  = 1'b0;
    mem.write_en = 1'b0;
    if (w_sel) begin
      mem.read_en  = p1.read_en;
      mem.write_en = p1.write_en & ~p1.read_en;
    end else begin
      mem.read_en  = p0.read_en;
      mem.write_en = p0.write_en & ~p0.read_en;
    end
  end

  assign mem.address    = w_addr;
  assign mem.write_data = w_wdata;

  assign p0.ready = ~w_pend0 | w_done0;
  assign p1.ready = ~w_pend1 | w_done1;

  assign p0.read_data = w_done0 ? mem.read_data : r_rd_buf0;
  assign p1.read_data = w_done1 ? mem.read_data : r_rd_buf1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_rd_buf0 <= '0;
      r_rd_buf1 <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_win;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Grant is held until the controller completes, even if
          // the owner drops its request early.
          if (mem.ready) begin
            r_state <= S_IDLE;
            if (r_owner) begin
              r_rd_buf1 <= mem.read_data;
            end else begin
              r_rd_buf0 <= mem.read_data;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a 5-cycle SRAM controller model.
// Tie-order expectations follow SRAM_ARB_ROUND_ROBIN_EN when defined.
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       busy;

  always #5 clk = ~clk;

  sram_arbiter_if #(.DATA_W(32), .ADDR_W(32)) p0_if ();
  sram_arbiter_if #(.DATA_W(32), .ADDR_W(32)) p1_if ();
  sram_arbiter_if #(.DATA_W(32), .ADDR_W(32)) mem_if ();

  sram_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .p0    (p0_if),
    .p1    (p1_if),
    .mem   (mem_if),
    .grant (grant),
    .busy  (busy)
  );

  // Controller model: accepts in idle, 4 busy cycles, then 1 done cycle.
  typedef enum logic [1:0] {C_IDLE, C_BUSY, C_DONE} cst_t;
  cst_t        c_state;
  int          c_cnt;
  logic [31:0] sram [0:1023];
  logic [31:0] c_rdata;

  assign mem_if.ready     = (c_state != C_BUSY);
  assign mem_if.read_data = c_rdata;

  always @(posedge clk) begin
    if (rst) begin
      c_state <= C_IDLE;
      c_cnt   <= 0;
    end else begin
      case (c_state)
        C_IDLE: begin
          if (mem_if.read_en || mem_if.write_en) begin
            c_state <= C_BUSY;
            c_cnt   <= 4;
            if (mem_if.read_en)
              c_rdata <= sram[mem_if.address[11:2]];
            else
              sram[mem_if.address[11:2]] <= mem_if.write_data;
          end
        end
        C_BUSY: begin
          if (c_cnt == 1) c_state <= C_DONE;
          else c_cnt <= c_cnt - 1;
        end
        default: c_state <= C_IDLE;
      endcase
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    p0_if.read_en    = 1'b0;
    p0_if.write_en   = 1'b0;
    p0_if.address    = '0;
    p0_if.write_data = '0;
    p1_if.read_en    = 1'b0;
    p1_if.write_en   = 1'b0;
    p1_if.address    = '0;
    p1_if.write_data = '0;
  endtask

  logic [1:0]  exp_g;
  logic [31:0] exp_d;

  initial begin
    for (int i = 0; i < 1024; i++)
      sram[i] = 32'hA500_0000 | i;
    c_rdata = '0;
    idle_all();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mre", mem_if.read_en, 1'b0);
    chk("rst_mwe", mem_if.write_en, 1'b0);
    chk("rst_p0rdy", p0_if.ready, 1'b1);
    chk("rst_p1rdy", p1_if.ready, 1'b1);
    chk("rst_p0rd", p0_if.read_data, 32'h0);
    chk("rst_p1rd", p1_if.read_data, 32'h0);

    // p0 single read
    p0_if.read_en = 1'b1;
    p0_if.address = 32'h400;
    #1;
    chk("s1_grant", grant, 2'b01);
    chk("s1_mre", mem_if.read_en, 1'b1);
    chk("s1_addr", mem_if.address, 32'h400);
    chk("s1_rdy_t", p0_if.ready, 1'b0);
    chk("s1_busy_t", busy, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("s1_rdy_wait", p0_if.ready, 1'b0);
      chk("s1_busy", busy, 1'b1);
    end
    tick();
    chk("s1_rdy_done", p0_if.ready, 1'b1);
    chk("s1_rdata", p0_if.read_data, 32'hA500_0100);
    idle_all();
    tick();
    chk("s1_idle_busy", busy, 1'b0);
    chk("s1_idle_grant", grant, 2'b00);
    chk("s1_rdbuf", p0_if.read_data, 32'hA500_0100);

    // p1 single write, p0 idle
    p1_if.write_en   = 1'b1;
    p1_if.address    = 32'h404;
    p1_if.write_data = 32'hDEAD_BEEF;
    #1;
    chk("s2_grant", grant, 2'b10);
    chk("s2_mwe", mem_if.write_en, 1'b1);
    chk("s2_mre", mem_if.read_en, 1'b0);
    chk("s2_wdata", mem_if.write_data, 32'hDEAD_BEEF);
    chk("s2_p1rdy_t", p1_if.ready, 1'b0);
    chk("s2_p0rdy_t", p0_if.ready, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("s2_p1rdy", p1_if.ready, 1'b0);
      chk("s2_p0rdy", p0_if.ready, 1'b1);
    end
    tick();
    chk("s2_p1rdy_done", p1_if.ready, 1'b1);
    chk("s2_p0rdy_done", p0_if.ready, 1'b1);
    idle_all();
    tick();
    chk("s2_sram", sram[32'h404 >> 2], 32'hDEAD_BEEF);

    // simultaneous reads; p0 served first after p1 was last
    p0_if.read_en = 1'b1;
    p0_if.address = 32'h410;
    p1_if.read_en = 1'b1;
    p1_if.address = 32'h414;
    #1;
    chk("s3_grant0", grant, 2'b01);
    chk("s3_p1rdy_t", p1_if.ready, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("s3_p1rdy_a", p1_if.ready, 1'b0);
    end
    tick();
    chk("s3_p0rdy_done", p0_if.ready, 1'b1);
    chk("s3_p1rdy_t5", p1_if.ready, 1'b0);
    chk("s3_p0rdata", p0_if.read_data, 32'hA500_0104);
    p0_if.read_en = 1'b0;
    tick();
    chk("s3_grant1", grant, 2'b10);
    chk("s3_mre1", mem_if.read_en, 1'b1);
    chk("s3_p1rdy_t6", p1_if.ready, 1'b0);
    for (int k = 7; k <= 10; k++) begin
      tick();
      chk("s3_p1rdy_b", p1_if.ready, 1'b0);
    end
    tick();
    chk("s3_p1rdy_done", p1_if.ready, 1'b1);
    chk("s3_p1rdata", p1_if.read_data, 32'hA500_0105);
    idle_all();
    tick();

    // both keep requesting for 4 transactions
    p0_if.read_en = 1'b1;
    p0_if.address = 32'h420;
    p1_if.read_en = 1'b1;
    p1_if.address = 32'h424;
    for (int n = 0; n < 4; n++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_g = n[0] ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      exp_d = exp_g[1] ? 32'hA500_0109 : 32'hA500_0108;
      #1;
      chk("s4_grant", grant, exp_g);
      repeat (5) tick();
      if (exp_g[1]) begin
        chk("s4_own_rdy", p1_if.ready, 1'b1);
        chk("s4_oth_rdy", p0_if.ready, 1'b0);
        chk("s4_rdata", p1_if.read_data, exp_d);
      end else begin
        chk("s4_own_rdy", p0_if.ready, 1'b1);
        chk("s4_oth_rdy", p1_if.ready, 1'b0);
        chk("s4_rdata", p0_if.read_data, exp_d);
      end
      if (n == 3) idle_all();
      tick();
    end

    // read and write together: only the read goes out
    p0_if.read_en    = 1'b1;
    p0_if.write_en   = 1'b1;
    p0_if.address    = 32'h408;
    p0_if.write_data = 32'h1234_5678;
    #1;
    chk("s5_mre", mem_if.read_en, 1'b1);
    chk("s5_mwe", mem_if.write_en, 1'b0);
    repeat (5) tick();
    chk("s5_rdy", p0_if.ready, 1'b1);
    chk("s5_rdata", p0_if.read_data, 32'hA500_0102);
    idle_all();
    tick();
    chk("s5_sram", sram[32'h408 >> 2], 32'hA500_0102);

    // reset pulsed at T+2 of a p1 write
    p1_if.write_en   = 1'b1;
    p1_if.address    = 32'h40C;
    p1_if.write_data = 32'hCAFE_F00D;
    #1;
    chk("s6_grant", grant, 2'b10);
    tick();
    tick();
    rst = 1'b1;
    idle_all();
    tick();
    rst = 1'b0;
    #1;
    chk("s6_grant_rst", grant, 2'b00);
    chk("s6_busy_rst", busy, 1'b0);
    chk("s6_mre_rst", mem_if.read_en, 1'b0);
    chk("s6_mwe_rst", mem_if.write_en, 1'b0);
    chk("s6_p1rd_rst", p1_if.read_data, 32'h0);
    p0_if.read_en = 1'b1;
    p0_if.address = 32'h400;
    #1;
    chk("s6_grant_new", grant, 2'b01);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("s6_rdy_wait", p0_if.ready, 1'b0);
    end
    tick();
    chk("s6_rdy_done", p0_if.ready, 1'b1);
    chk("s6_rdata", p0_if.read_data, 32'hA500_0100);
    idle_all();
    tick();
    chk("s6_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
